dmem_wait_ctrl: RTL and testbench
=================================

DMEM_WAIT_CTRL -- requirements
Module: dmem_wait_ctrl

Interface
REQ-001 Parameter LATENCY, default 2, SHALL set the wait cycles added before each access (legal range 0..15).
REQ-002 Parameter DEPTH_WORDS, default 256, SHALL set storage depth in 32-bit words (power of two).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 mem_req  input  1  SHALL be the access request strobe.
REQ-006 mem_we  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-007 addr  input  32  SHALL be the byte address (ALU result).
REQ-008 wdata  input  32  SHALL be the store data (register-file read port 2).
REQ-009 rdata  output  32  SHALL be the registered load data.
REQ-010 ready  output  1  SHALL be a one-cycle completion pulse.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 err  output  1  SHALL be the misaligned-access flag, valid only with ready.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-014 In IDLE, mem_req=1 at an edge SHALL capture addr, mem_we and wdata, load cnt=LATENCY, and enter ACCESS.
REQ-015 In ACCESS with cnt!=0, each edge SHALL decrement cnt.
REQ-016 In ACCESS with cnt==0, the next edge SHALL perform the access on the captured values and enter DONE.
REQ-017 In DONE, ready SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-018 Latency: with the request accepted at edge E0, ready SHALL be high in the cycle following edge E(LATENCY+1).
REQ-019 mem_req and input changes while busy=1 SHALL be ignored; no queuing.
REQ-020 A request SHALL NOT be accepted in DONE, so back-to-back accesses are spaced LATENCY+3 cycles apart.
REQ-021 Word index SHALL be the captured addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored and the index wraps modulo DEPTH_WORDS.
REQ-022 A write SHALL update the word at the completing edge; rdata SHALL then show the written data.
REQ-023 A read SHALL load rdata with the stored word at the completing edge.
REQ-024 rdata SHALL hold its value until the next completed access.
REQ-025 A read of a never-written word SHALL return whatever the storage holds; the bench SHALL NOT check it.

Reset
REQ-026 With reset=0 at an edge, the block SHALL enter IDLE with ready=0, busy=0, err=0, rdata=0 and cnt=0.
REQ-027 Reset during ACCESS SHALL abort the access; a pending write SHALL NOT be committed.
REQ-028 Storage contents SHALL be unaffected by reset.
REQ-029 reset SHALL take priority over mem_req on the same edge.

Configuration
REQ-030 With macro DMEM_ALIGN_CHECK_EN defined, captured addr[1:0]!=0 SHALL have these effects:
  - err is 1 together with ready;
  - a write is suppressed;
  - a read returns rdata=0;
  - the access still completes normally.
REQ-031 Without DMEM_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-032 LATENCY=2: write addr=0x10, wdata=0xDEADBEEF accepted at E0 -> ready=1 only in the cycle after E3; busy=1 from E0 to E3.
REQ-033 After that write, read addr=0x10 -> rdata=0xDEADBEEF with ready, err=0.
REQ-034 DEPTH_WORDS=256: write 0x12345678 to addr=0x400, then read addr=0x0 -> rdata=0x12345678 (wrap-around).
REQ-035 mem_req pulsed again during ACCESS with addr=0x20 -> ignored; exactly one ready pulse, for the original access.
REQ-036 Write 0xAAAA5555 to 0x8 with reset=0 applied at E1 (LATENCY=2) -> no ready pulse; a later read of 0x8 returns the prior contents, not 0xAAAA5555.
REQ-037 With DMEM_ALIGN_CHECK_EN defined: write to addr=0x13 -> err=1 with ready and memory unchanged; read addr=0x13 -> rdata=0, err=1.

Source files
------------

// File: rtl/dmem_wait_ctrl.sv
// Data memory with programmable wait states and a ready/busy handshake.
// Optional misalignment check: define DMEM_ALIGN_CHECK_EN.
module dmem_wait_ctrl #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          misal;
  logic          fire;
  logic          mem_wr;
  logic          unused_addr;

  assign idx = addr_q[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misal = |addr_q[1:0];
`else
  assign misal = 1'b0;
`endif

  assign unused_addr = ^{addr_q[31:AW+2], addr_q[1:0]};

  assign fire = (state_q == ACCESS) && (cnt_q == 4'd0);
  // reset gates the write so an aborted store never lands
  assign mem_wr = fire && we_q && !misal && reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = mem_we;
          cnt_d   = 4'(LATENCY);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (misal)     rdata_d = 32'd0;
          else if (we_q) rdata_d = wdata_q;
          else           rdata_d = mem[idx];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (mem_wr) mem[idx] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);
  assign err   = ready && misal;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Self-checking bench for dmem_wait_ctrl: vector table, corner
// sequences and randomized accesses against a word-array model.
module tb_dmem_wait_ctrl;

  localparam int L = 2;
  localparam int D = 256;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int n_chk;
  int n_fail;

  logic [31:0] model [D];
  bit          valid [D];

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  dmem_wait_ctrl #(
    .LATENCY(L),
    .DEPTH_WORDS(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % D);
  endfunction

  task automatic mwr(input logic [31:0] a, input logic [31:0] d);
    model[widx(a)] = d;
    valid[widx(a)] = 1'b1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // mode: 0 quiet, 1 random input noise while busy, 2 one stray req to 0x20
  task automatic acc(input logic we, input logic [31:0] a,
                     input logic [31:0] d, input int mode,
                     input bit chk, input logic [31:0] exp,
                     input logic exp_err, input string nm);
    int got;
    bit bsy_ok;
    got = 0;
    bsy_ok = 1'b1;
    mem_req = 1'b1;
    mem_we = we;
    addr = a;
    wdata = d;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      @(negedge clk);
      if (ready) begin
        got = k;
        if (!busy) bsy_ok = 1'b0;
      end else begin
        if (!busy) bsy_ok = 1'b0;
        if (mode == 1) begin
          mem_req = 1'($urandom);
          mem_we = 1'($urandom);
          addr = $urandom;
          wdata = $urandom;
        end else if (mode == 2 && k == 1) begin
          mem_req = 1'b1;
          mem_we = 1'b1;
          addr = 32'h20;
          wdata = 32'hBAD0BAD0;
        end else begin
          mem_req = 1'b0;
        end
      end
    end
    check({nm, "_latency"}, 32'(got), 32'(L + 2));
    check({nm, "_busy"}, 32'(bsy_ok), 32'd1);
    if (got > 0) begin
      if (chk) check({nm, "_rdata"}, rdata, exp);
      check({nm, "_err"}, 32'(err), 32'(exp_err));
      @(negedge clk);
      check({nm, "_pulse"}, {30'd0, ready, busy}, 32'd0);
    end
    mem_req = 1'b0;
  endtask

  initial begin
    int cnt;
    logic        rwe;
    logic [31:0] ra;
    logic [31:0] rd;
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < D; i++) valid[i] = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h0000_0400, 32'h12345678, 32'h12345678};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 32'h0000_03FC, 32'h0BADF00D, 32'h0BADF00D};
    vecs[5] = '{1'b0, 32'hFFFF_F3FC, 32'h0,        32'h0BADF00D};
    vecs[6] = '{1'b1, 32'h0000_0004, 32'h11111111, 32'h11111111};
    vecs[7] = '{1'b1, 32'h8000_0404, 32'h22222222, 32'h22222222};
    vecs[8] = '{1'b0, 32'h0000_0004, 32'h0,        32'h22222222};
    vecs[9] = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF};

    reset = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    addr = 32'd0;
    wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      acc(vecs[i].we, vecs[i].a, vecs[i].d, 0, 1'b1, vecs[i].exp,
          1'b0, $sformatf("vec%0d", i));
      if (vecs[i].we) mwr(vecs[i].a, vecs[i].d);
    end

    // stray request during ACCESS must be dropped
    acc(1'b1, 32'h20, 32'hC0FFEE00, 0, 1'b1, 32'hC0FFEE00, 1'b0, "w20");
    mwr(32'h20, 32'hC0FFEE00);
    acc(1'b1, 32'h10, 32'h5555AAAA, 2, 1'b1, 32'h5555AAAA, 1'b0, "stray");
    mwr(32'h10, 32'h5555AAAA);
    acc(1'b0, 32'h20, 32'h0, 0, 1'b1, 32'hC0FFEE00, 1'b0, "r20");

    // reset mid-access aborts the pending write
    acc(1'b1, 32'h8, 32'h5A5A0000, 0, 1'b1, 32'h5A5A0000, 1'b0, "w8");
    mwr(32'h8, 32'h5A5A0000);
    mem_req = 1'b1;
    mem_we = 1'b1;
    addr = 32'h8;
    wdata = 32'hAAAA5555;
    @(negedge clk);
    check("abort_busy0", 32'(busy), 32'd1);
    mem_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy1", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    check("abort_noready", 32'(cnt), 32'd0);
    acc(1'b0, 32'h8, 32'h0, 0, 1'b1, 32'h5A5A0000, 1'b0, "r8");

    // reset wins over a simultaneous request
    mem_req = 1'b1;
    mem_we = 1'b1;
    addr = 32'h10;
    wdata = 32'hFEEDFACE;
    reset = 1'b0;
    @(negedge clk);
    check("prio_busy", 32'(busy), 32'd0);
    mem_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    acc(1'b0, 32'h10, 32'h0, 0, 1'b1, 32'h5555AAAA, 1'b0, "prio_r");

`ifdef DMEM_ALIGN_CHECK_EN
    acc(1'b1, 32'h13, 32'hFFFF0000, 0, 1'b0, 32'h0, 1'b1, "mis_w");
    acc(1'b0, 32'h10, 32'h0, 0, 1'b1, 32'h5555AAAA, 1'b0, "mis_chk");
    acc(1'b0, 32'h13, 32'h0, 0, 1'b1, 32'h0, 1'b1, "mis_r");
`else
    acc(1'b1, 32'h13, 32'h77778888, 0, 1'b1, 32'h77778888, 1'b0, "lo_w");
    mwr(32'h13, 32'h77778888);
    acc(1'b0, 32'h10, 32'h0, 0, 1'b1, 32'h77778888, 1'b0, "lo_r");
`endif

    for (int i = 0; i < 150; i++) begin
      rwe = 1'($urandom);
      ra = $urandom & 32'hFFFF_FFFC;
      rd = $urandom;
      if (rwe) begin
        acc(1'b1, ra, rd, int'($urandom % 2), 1'b1, rd, 1'b0, "rnd_w");
        mwr(ra, rd);
      end else begin
        acc(1'b0, ra, 32'h0, int'($urandom % 2), valid[widx(ra)],
            model[widx(ra)], 1'b0, "rnd_r");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
